// File: rtl/ram_word_port_pkg.sv
// Shared types and helpers for the word-to-byte RAM access sequencer.
package ram_word_port_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } state_t;

    // Result of a lane search: lane index plus a flag set when no lane qualifies.
    typedef struct packed {
        logic  none;
        lane_t lane;
    } lane_pick_t;

    // Lowest enabled lane strictly above cur; none=1 when cur was the last one.
    function automatic lane_pick_t next_lane(input logic [LANES-1:0] be, input lane_t cur);
        lane_pick_t r;
        r.none = 1'b1;
        r.lane = '0;
        // Descending scan so the lowest qualifying lane is the one left standing.
        for (int unsigned i = LANES; i > 0; i--) begin
            if ((i - 1) > 32'(cur) && be[i-1]) begin
                r.none = 1'b0;
                r.lane = lane_t'(i - 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_lane_sel.sv
// Priority lane picker: first enabled lane of a mask, and next enabled lane above cur.
module ram_lane_sel
    import ram_word_port_pkg::*;
(
    input  logic [LANES-1:0] mask,
    input  lane_t            cur,
    output lane_t            first_lane,
    output logic             first_none,
    output lane_t            next_idx,
    output logic             next_none
);

    lane_pick_t nxt;

    // Lowest set bit of the mask, used when a request is accepted.
    always_comb begin
        first_lane = '0;
        first_none = 1'b1;
        for (int unsigned i = LANES; i > 0; i--) begin
            if (mask[i-1]) begin
                first_lane = lane_t'(i - 1);
                first_none = 1'b0;
            end
        end
    end

    // Successor lane while a request is being sequenced.
    always_comb begin
        nxt       = next_lane(mask, cur);
        next_idx  = nxt.lane;
        next_none = nxt.none;
    end

endmodule

// File: rtl/ram_word_port.sv
// Word-to-byte access sequencer: splits one 32-bit load/store into byte RAM
// accesses in ascending lane order and reassembles loads little-endian.
module ram_word_port
    import ram_word_port_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned LANES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [ADDR_W-1:0]    i_req_addr,
    input  logic [LANES-1:0]     i_req_be,
    input  logic [8*LANES-1:0]   i_req_wdata,
    output logic                 o_rsp_valid,
    output logic [8*LANES-1:0]   o_rdata,
    output logic                 o_ram_we,
    output logic [ADDR_W-1:0]    o_ram_waddr,
    output logic [ADDR_W-1:0]    o_ram_raddr,
    output logic [7:0]           o_ram_wdata,
    input  logic [7:0]           i_ram_rdata
);

    state_t                state_q, state_d;

    logic                  we_q;
    logic [ADDR_W-3:0]     base_q;
    logic [LANES-1:0]      be_q;
    logic [8*LANES-1:0]    wdata_q;
    lane_t                 lane_q;
    lane_t                 cap_lane_q;
    logic                  cap_pend_q;
    logic [8*LANES-1:0]    asm_q;
    logic [8*LANES-1:0]    asm_cap;
    logic [8*LANES-1:0]    rdata_q;

    logic                  ram_we_q;
    logic [ADDR_W-1:0]     waddr_q;
    logic [ADDR_W-1:0]     raddr_q;
    logic [7:0]            ram_wdata_q;

    logic [LANES-1:0]      sel_mask;
    lane_t                 first_lane;
    logic                  first_none;
    lane_t                 next_idx;
    logic                  next_none;
    logic                  accept;

    // Word base only; the byte offset bits of the request address are don't-care.
    logic                  unused_addr_bits;
    assign unused_addr_bits = &i_req_addr[1:0];

    assign accept   = (state_q == IDLE) && i_req_valid;
    assign sel_mask = (state_q == IDLE) ? i_req_be : be_q;

    ram_lane_sel u_lane_sel (
        .mask       (sel_mask),
        .cur        (lane_q),
        .first_lane (first_lane),
        .first_none (first_none),
        .next_idx   (next_idx),
        .next_none  (next_none)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; lane sequencing ends when no enabled lane remains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    if (first_none)    state_d = RESP;
                    else if (i_req_we) state_d = WRITE;
                    else               state_d = READ;
                end
            end
            WRITE:   if (next_none) state_d = RESP;
            READ:    if (next_none) state_d = DRAIN;
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Assembly register with the byte returned for the previously issued read lane merged in.
    always_comb begin
        asm_cap = asm_q;
        asm_cap[{cap_lane_q, 3'b000} +: 8] = i_ram_rdata;
    end

    // Request latch, RAM port registers and load assembly.
    // RAM-side outputs are registered one lane ahead so the first access lands in the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            base_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            lane_q      <= '0;
            cap_lane_q  <= '0;
            cap_pend_q  <= 1'b0;
            asm_q       <= '0;
            rdata_q     <= '0;
            ram_we_q    <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            ram_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q       <= i_req_we;
                        base_q     <= i_req_addr[ADDR_W-1:2];
                        be_q       <= i_req_be;
                        wdata_q    <= i_req_wdata;
                        asm_q      <= '0;
                        lane_q     <= first_lane;
                        cap_pend_q <= 1'b0;
                        if (first_none) begin
                            if (!i_req_we) rdata_q <= '0;
                        end else if (i_req_we) begin
                            ram_we_q    <= 1'b1;
                            waddr_q     <= {i_req_addr[ADDR_W-1:2], first_lane};
                            ram_wdata_q <= i_req_wdata[{first_lane, 3'b000} +: 8];
                        end else begin
                            raddr_q <= {i_req_addr[ADDR_W-1:2], first_lane};
                        end
                    end
                end
                WRITE: begin
                    if (next_none) begin
                        ram_we_q <= 1'b0;
                    end else begin
                        lane_q      <= next_idx;
                        waddr_q     <= {base_q, next_idx};
                        ram_wdata_q <= wdata_q[{next_idx, 3'b000} +: 8];
                    end
                end
                READ: begin
                    if (cap_pend_q) asm_q <= asm_cap;
                    cap_lane_q <= lane_q;
                    cap_pend_q <= 1'b1;
                    if (!next_none) begin
                        lane_q  <= next_idx;
                        raddr_q <= {base_q, next_idx};
                    end
                end
                DRAIN: begin
                    asm_q      <= asm_cap;
                    cap_pend_q <= 1'b0;
                    if (!we_q) rdata_q <= asm_cap;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rdata     = rdata_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_waddr = waddr_q;
    assign o_ram_raddr = raddr_q;
    assign o_ram_wdata = ram_wdata_q;

endmodule
